// File: rtl/full_sub.sv
// One-bit full subtractor computing a - b - c.
// OUT_REG selects registered outputs (one-cycle latency) or a purely combinational path.
module full_sub #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borr
);

  logic diff_d;
  logic borr_d;

  // Borrow out whenever the subtrahend plus borrow-in exceeds the minuend.
  always_comb begin
    diff_d = a ^ b ^ c;
    borr_d = (~a & (b | c)) | (b & c);
  end

  if (OUT_REG) begin : g_reg
    logic diff_q;
    logic borr_q;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        diff_q <= 1'b0;
        borr_q <= 1'b0;
      end else begin
        diff_q <= diff_d;
        borr_q <= borr_d;
      end
    end

    assign diff = diff_q;
    assign borr = borr_q;
  end else begin : g_comb
    assign diff = diff_d;
    assign borr = borr_d;
  end

endmodule

// File: tb/tb_full_sub.sv
// Directed self-checking bench for full_sub, covering the registered and the combinational build.
module tb_full_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b1;
  logic c = 1'b1;
  logic diff;
  logic borr;

  // The combinational instance gets its own stimulus and a clock that never toggles.
  logic clk_c = 1'b0;
  logic rst_c = 1'b0;
  logic ca = 1'b0;
  logic cb = 1'b0;
  logic cc = 1'b0;
  logic diff_c;
  logic borr_c;

  int checks = 0;
  int errors = 0;

  // Hand-written truth table for abc -> {diff,borr}.
  logic [1:0] exp_tab [8];

  full_sub #(.OUT_REG(1'b1)) u_reg (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .diff(diff),
    .borr(borr)
  );

  full_sub #(.OUT_REG(1'b0)) u_comb (
    .clk (clk_c),
    .rst (rst_c),
    .a   (ca),
    .b   (cb),
    .c   (cc),
    .diff(diff_c),
    .borr(borr_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, then check #1 after the following rising edge.
  task automatic step(input logic [2:0] abc, input logic r, input logic [1:0] exp, input string tag);
    @(negedge clk);
    {a, b, c} = abc;
    rst = r;
    @(posedge clk);
    #1;
    check(tag, {diff, borr}, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_tab[0] = 2'b00;
    exp_tab[1] = 2'b11;
    exp_tab[2] = 2'b11;
    exp_tab[3] = 2'b01;
    exp_tab[4] = 2'b10;
    exp_tab[5] = 2'b00;
    exp_tab[6] = 2'b00;
    exp_tab[7] = 2'b11;

    // Reset held with abc=011 for two cycles, then released.
    step(3'b011, 1'b1, 2'b00, "reset_cyc1");
    step(3'b011, 1'b1, 2'b00, "reset_cyc2");
    step(3'b011, 1'b0, 2'b01, "reset_release");

    // Exhaustive registered sweep.
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b0, exp_tab[i], $sformatf("sweep_%0d", i));
    end

    // Borrow corners.
    step(3'b001, 1'b0, 2'b11, "corner_001");
    step(3'b111, 1'b0, 2'b11, "corner_111");
    step(3'b100, 1'b0, 2'b10, "corner_100");

    // Reset wins over non-zero inputs.
    step(3'b111, 1'b1, 2'b00, "reset_priority");

    // Mid-stream reset with no residue afterwards.
    step(3'b010, 1'b0, 2'b11, "mid_pre");
    step(3'b010, 1'b1, 2'b00, "mid_rst");
    step(3'b110, 1'b0, 2'b00, "mid_resume");
    step(3'b111, 1'b0, 2'b11, "mid_after");

    // Hold: inputs toggle between edges, outputs move only at the edge.
    step(3'b100, 1'b0, 2'b10, "hold_base");
    {a, b, c} = 3'b011;
    #2;
    check("hold_mid1", {diff, borr}, 2'b10);
    {a, b, c} = 3'b001;
    #1;
    check("hold_mid2", {diff, borr}, 2'b10);
    @(negedge clk);
    {a, b, c} = 3'b111;
    #2;
    check("hold_mid3", {diff, borr}, 2'b10);
    @(posedge clk);
    #1;
    check("hold_edge", {diff, borr}, 2'b11);

    // Combinational build: no clock, rst toggled to show it has no effect.
    for (int i = 0; i < 8; i++) begin
      {ca, cb, cc} = 3'(i);
      rst_c = (i >= 4);
      #10;
      check($sformatf("comb_%0d", i), {diff_c, borr_c}, exp_tab[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_sub.md
FULL_SUB -- requirements
Module: full_sub

Interface
REQ-001 Parameter OUT_REG, default 1, meaning: 1 = registered outputs with one-cycle latency; 0 = purely combinational outputs.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  1  minuend bit.
REQ-005 b  input  1  subtrahend bit.
REQ-006 c  input  1  borrow-in bit.
REQ-007 diff  output  1  difference bit of a - b - c.
REQ-008 borr  output  1  borrow-out bit of a - b - c.
REQ-009 Port order SHALL be clk, rst, a, b, c, diff, borr.

Function
REQ-010 The block SHALL compute the one-bit full subtraction a - b - c, with {a,b,c} treated as a 3-bit input vector and a as MSB.
REQ-011 diff SHALL equal a XOR b XOR c.
REQ-012 borr SHALL equal (NOT a AND (b OR c)) OR (b AND c), i.e. 1 whenever b + c > a.
REQ-013 Truth table for abc -> diff,borr: 000->0,0; 001->1,1; 010->1,1; 011->0,1; 100->1,0; 101->0,0; 110->0,0; 111->1,1.
REQ-014 With OUT_REG=1, diff and borr SHALL be registered and SHALL update on each rising clk edge from the a,b,c values sampled at that edge, giving exactly one cycle of latency.
REQ-015 With OUT_REG=1, outputs SHALL hold their value between clock edges regardless of input changes.
REQ-016 With OUT_REG=0, diff and borr SHALL follow a, b, c combinationally with zero cycles of latency, and clk/rst SHALL have no effect.
REQ-017 No internal state SHALL exist besides the two output registers; there is no handshake, and a new input is accepted every cycle.
REQ-018 X or Z on any input SHALL NOT be given defined behaviour; inputs SHALL be driven to known values.

Reset
REQ-019 With OUT_REG=1, when rst is sampled high on a rising clk edge, diff and borr SHALL both become 0 on that edge.
REQ-020 Reset SHALL take priority over input sampling: while rst is high, the outputs SHALL stay 0 irrespective of a, b, c.
REQ-021 On the first rising edge with rst low, the outputs SHALL reflect the a, b, c values sampled on that edge.
REQ-022 Reset asserted mid-stream SHALL clear the outputs on the next edge, with no residual effect after deassertion.
REQ-023 Output values before the first reset SHALL be treated as undefined by verification.

Verification
REQ-024 Exhaustive sweep: with OUT_REG=1, apply all 8 abc codes, one per cycle from 000 to 111 -> each output pair matches REQ-013 one cycle later.
REQ-025 Borrow corners: abc=001 -> diff=1, borr=1; abc=111 -> diff=1, borr=1; abc=100 -> diff=1, borr=0.
REQ-026 Reset: drive abc=011 with rst=1 for 2 cycles -> outputs 0,0; release rst -> the next edge gives diff=0, borr=1.
REQ-027 Mid-stream reset: apply abc=010, then assert rst for one cycle -> outputs 1,1 then 0,0; resume abc=110 -> outputs 0,0.
REQ-028 Hold: toggle abc between clock edges -> outputs change only at rising edges.
REQ-029 Combinational build: with OUT_REG=0, sweep all 8 codes at 10 ns intervals with no clock -> outputs match REQ-013 immediately.
